// File: rtl/recv_port_arbiter_if.sv
// Bundle between the port arbiter, its octet sources and the shared frame receiver.
// slave = arbiter view, master = environment (sources + receiver) view.
interface recv_port_arbiter_if #(
  parameter int NUM_PORTS = 4
) ();
  logic [NUM_PORTS-1:0]      req;
  logic [NUM_PORTS-1:0][7:0] data_in;
  logic [NUM_PORTS-1:0]      gnt;
  logic [7:0]                rx_data;
  logic                      rx_start;
  logic                      rx_rst;
  logic [7:0]                rx_out;
  logic                      rx_vld;
  logic                      rx_rdy;

  modport slave (
    input  req, data_in, rx_out, rx_vld, rx_rdy,
    output gnt, rx_data, rx_start, rx_rst
  );

  modport master (
    output req, data_in, rx_out, rx_vld, rx_rdy,
    input  gnt, rx_data, rx_start, rx_rst
  );
endinterface

// File: rtl/recv_port_arbiter.sv
// Round-robin share of one frame receiver among NUM_PORTS octet sources,
// with outcome classification, saturating frame counters and a RUN watchdog.
module recv_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  localparam int PW            = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  recv_port_arbiter_if.slave   bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [PW-1:0]        done_port_o,
  output logic [1:0]           done_status_o,
  output logic [15:0]          ok_cnt_o,
  output logic [15:0]          err_cnt_o
);

  typedef enum logic [1:0] {ARB, GRANT, RUN} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] sel_q;
  logic [15:0]   tmr_q;
  logic          prev_vld_q;
  logic [7:0]    prev_out_q;
  logic [15:0]   ok_cnt_q;
  logic [15:0]   err_cnt_q;

  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic          found;
  logic          fin;
  logic          wdog;
  logic [1:0]    cls;
  logic [1:0]    status;

  // First requester strictly after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Classification looks at the receiver's last non-idle cycle.
  always_comb begin
    if (prev_vld_q && prev_out_q == 8'h00)           cls = 2'b00;
    else if (prev_vld_q && prev_out_q[7:4] == 4'hF)  cls = 2'b01;
    else                                             cls = 2'b10;
  end

  assign fin    = (state_q == RUN) && bus.rx_rdy;
  assign wdog   = (state_q == RUN) && !bus.rx_rdy && (tmr_q == TMO_LAST);
  assign status = fin ? cls : 2'b11;

  always_comb begin
    bus.gnt = '0;
    if (!rst && state_q != ARB) bus.gnt[sel_q] = 1'b1;
  end

  assign bus.rx_data   = (!rst && state_q != ARB) ? bus.data_in[sel_q] : 8'h00;
  assign bus.rx_start  = !rst && (state_q == GRANT);
  assign bus.rx_rst    = rst || wdog;
  assign busy_o        = !rst && (state_q != ARB);
  assign done_o        = !rst && (fin || wdog);
  assign done_port_o   = done_o ? sel_q : '0;
  assign done_status_o = done_o ? status : 2'b00;
  assign ok_cnt_o      = ok_cnt_q;
  assign err_cnt_o     = err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= PW'(NUM_PORTS - 1);
      sel_q      <= '0;
      tmr_q      <= '0;
      prev_vld_q <= 1'b0;
      prev_out_q <= 8'h00;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      prev_vld_q <= bus.rx_vld;
      prev_out_q <= bus.rx_out;

      if (done_o) begin
        if (status == 2'b00) begin
          if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
        end else if (status != 2'b10) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
      end

      case (state_q)
        ARB: begin
          if (bus.rx_rdy && |bus.req) begin
            sel_q    <= pick;
            rr_ptr_q <= pick;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          tmr_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // Completion takes priority over the watchdog in the same cycle.
          if (fin || wdog) state_q <= ARB;
          else             tmr_q   <= tmr_q + 16'd1;
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_port_arbiter.sv
// Bench for recv_port_arbiter: behavioural sources and receiver, scoreboard of
// expected (port, status) in completion order, counter model.
module tb_recv_port_arbiter;
  localparam int NP  = 4;
  localparam int TMO = 50;
  localparam int PW  = $clog2(NP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recv_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

  logic          busy, done;
  logic [PW-1:0] done_port;
  logic [1:0]    done_status;
  logic [15:0]   ok_cnt, err_cnt;

  recv_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .done_o(done), .done_port_o(done_port),
    .done_status_o(done_status), .ok_cnt_o(ok_cnt), .err_cnt_o(err_cnt)
  );

  typedef struct { int port; logic [1:0] st; } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;
  int nfr   = 0;
  int nwd   = 0;
  logic [15:0] exp_ok = 0;
  logic [15:0] exp_err = 0;
  logic [47:0] dmac;

  logic [7:0] fstore [64][280];
  int         flen   [64];
  int         pq     [NP][$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // kind: 0 good, 1 bad SFD, 2 wrong dest MAC
  task automatic send(input int p, input int kind, input int plen,
                      input logic [1:0] st, input bit track);
    int id;
    logic [7:0] lrc;
    id = nfr;
    nfr++;
    for (int i = 0; i < 7; i++) fstore[id][i] = 8'hAA;
    fstore[id][7] = (kind == 1) ? 8'hAA : 8'hD5;
    for (int i = 0; i < 6; i++) fstore[id][8+i] = dmac[47-8*i -: 8];
    if (kind == 2) fstore[id][13] = fstore[id][13] ^ 8'h55;
    for (int i = 0; i < 6; i++) fstore[id][14+i] = 8'(8'h10 + i);
    fstore[id][20] = plen[15:8];
    fstore[id][21] = plen[7:0];
    for (int i = 0; i < plen; i++) fstore[id][22+i] = 8'($urandom);
    lrc = 8'h00;
    for (int i = 8; i < 22 + plen; i++) lrc = lrc ^ fstore[id][i];
    fstore[id][22+plen] = lrc;
    flen[id] = 23 + plen;
    pq[p].push_back(id);
    if (track) sbq.push_back('{p, st});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
  endtask

  // Sources: stream one octet per cycle while granted.
  bit act [NP];
  int cur [NP];
  int idx [NP];
  initial begin
    bus.req     = '0;
    bus.data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (bus.gnt[p]) begin
          if (!act[p]) begin
            act[p] = 1'b1;
            idx[p] = 0;
            cur[p] = (pq[p].size() != 0) ? pq[p].pop_front() : 0;
          end
          bus.data_in[p] = (idx[p] < flen[cur[p]]) ? fstore[cur[p]][idx[p]] : 8'h00;
          idx[p]++;
        end else begin
          act[p]         = 1'b0;
          bus.data_in[p] = 8'h00;
        end
        bus.req[p] = (pq[p].size() != 0);
      end
    end
  end

  // Receiver model: F1 bad preamble, F2 bad SFD, F3 bad FCS, 00 good, vld=0 on dest mismatch.
  int         rph, rcnt, rlen;
  bit         dmis, s_rst, s_st;
  logic [7:0] s_d, rlrc;
  initial begin
    bus.rx_out = 8'h00;
    bus.rx_vld = 1'b0;
    bus.rx_rdy = 1'b1;
    rph = 0;
    forever begin
      @(negedge clk);
      s_rst = bus.rx_rst;
      s_st  = bus.rx_start;
      s_d   = bus.rx_data;
      @(posedge clk);
      #1;
      if (s_rst || rph == 2) begin
        rph = 0; bus.rx_rdy = 1'b1; bus.rx_vld = 1'b0; bus.rx_out = 8'h00;
      end else if (rph == 1 || (rph == 0 && s_st)) begin
        if (rph == 0) begin
          rph = 1; rcnt = 0; rlen = 1 << 20; rlrc = 8'h00; dmis = 1'b0; bus.rx_rdy = 1'b0;
        end
        if (rcnt < 7 && s_d != 8'hAA) begin
          rph = 2; bus.rx_vld = 1'b1; bus.rx_out = 8'hF1;
        end else if (rcnt == 7 && s_d != 8'hD5) begin
          rph = 2; bus.rx_vld = 1'b1; bus.rx_out = 8'hF2;
        end else begin
          if (rcnt >= 8 && rcnt < 14 && s_d != dmac[47-8*(rcnt-8) -: 8]) dmis = 1'b1;
          if (rcnt == 20) rlen = int'(s_d) << 8;
          if (rcnt == 21) rlen = rlen | int'(s_d);
          if (rcnt == 13 && dmis) begin
            rph = 2; bus.rx_vld = 1'b0; bus.rx_out = 8'h00;
          end else if (rcnt == 22 + rlen) begin
            rph = 2; bus.rx_vld = 1'b1; bus.rx_out = (s_d == rlrc) ? 8'h00 : 8'hF3;
          end else if (rcnt >= 8) begin
            rlrc = rlrc ^ s_d;
          end
          rcnt++;
        end
      end
    end
  end

  // Monitor: grant target, arbitration gap, watchdog cycle, scoreboard pop.
  int   runc = 0;
  bit   pbusy = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rx_start) begin
          chk("arb_gap", 32'(pbusy), 0);
          if (sbq.size() != 0) chk("gnt", 32'(bus.gnt), 32'(1) << sbq[0].port);
          runc = -1;
        end else if (busy) begin
          runc++;
        end
        if (bus.rx_rst) begin
          nwd++;
          chk("wdog_cycle", runc, TMO - 1);
        end
        if (done) begin
          if (sbq.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("done_port", 32'(done_port), e.port);
            chk("done_status", 32'(done_status), 32'(e.st));
            if (e.st == 2'b00 && exp_ok != 16'hFFFF) exp_ok = exp_ok + 1;
            if ((e.st == 2'b01 || e.st == 2'b11) && exp_err != 16'hFFFF) exp_err = exp_err + 1;
          end
        end
      end
      pbusy = busy;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    dmac = 48'h02_00_00_00_00_01;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx_rst", 32'(bus.rx_rst), 1);
    chk("rst_rx_start", 32'(bus.rx_start), 0);
    chk("rst_rx_data", 32'(bus.rx_data), 0);
    chk("rst_ok", 32'(ok_cnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_rst", 32'(bus.rx_rst), 0);

    // Port 1 alone, good frame
    send(1, 0, 4, 2'b00, 1);
    wait_idle(300);
    chk("t1_ok", 32'(ok_cnt), 32'(exp_ok));
    chk("t1_ok_abs", 32'(ok_cnt), 1);

    // All ports requesting, two rounds from a fresh pointer
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) send(p, 0, 1, 2'b00, 1);
    wait_idle(1500);
    chk("t2_ok", 32'(ok_cnt), 8);

    // Bad SFD on port 2
    send(2, 1, 4, 2'b01, 1);
    wait_idle(300);
    chk("t3_err", 32'(err_cnt), 1);
    chk("t3_ok", 32'(ok_cnt), 32'(exp_ok));

    // Wrong dest MAC: counters unchanged
    send(3, 2, 4, 2'b10, 1);
    wait_idle(300);
    chk("t4_ok", 32'(ok_cnt), 8);
    chk("t4_err", 32'(err_cnt), 1);

    // Long frame trips the watchdog, then port 0 recovers
    send(1, 0, 256, 2'b11, 1);
    wait_idle(400);
    chk("t5_wdog_seen", nwd, 1);
    chk("t5_err", 32'(err_cnt), 2);
    send(0, 0, 4, 2'b00, 1);
    wait_idle(300);
    chk("t5_ok", 32'(ok_cnt), 9);

    // Reset in the middle of a payload
    send(2, 0, 20, 2'b00, 0);
    begin
      int n;
      n = 0;
      while (!busy && n < 50) begin @(negedge clk); n++; end
      chk("t6_started", 32'(busy), 1);
    end
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.gnt), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rx_rst", 32'(bus.rx_rst), 1);
    chk("t6_ok", 32'(ok_cnt), 0);
    chk("t6_err", 32'(err_cnt), 0);
    @(negedge clk);
    rst     = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    @(negedge clk);
    send(0, 0, 4, 2'b00, 1);
    wait_idle(300);
    chk("t6_ok_after", 32'(ok_cnt), 1);

    // Saturation of ok_cnt
    force dut.ok_cnt_q = 16'hFFFE;
    #1;
    release dut.ok_cnt_q;
    exp_ok = 16'hFFFE;
    @(negedge clk);
    send(1, 0, 2, 2'b00, 1);
    send(2, 0, 2, 2'b00, 1);
    send(0, 0, 2, 2'b00, 1);
    wait_idle(600);
    chk("t7_ok_sat", 32'(ok_cnt), 32'hFFFF);
    chk("t7_ok_model", 32'(ok_cnt), 32'(exp_ok));
    chk("t7_err", 32'(err_cnt), 0);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
